// File: rtl/bpu_update_sched_if.sv
// bpu_update_sched_if: request, update and init-sweep signals of the predictor update scheduler
interface bpu_update_sched_if #(
  parameter int PAY_W = 64,
  parameter int DEPTH = 4,
  parameter int IDX_W = 8
);
  logic                       req0_valid;
  logic [PAY_W-1:0]           req0_data;
  logic                       req0_ready;
  logic                       req1_valid;
  logic [PAY_W-1:0]           req1_data;
  logic                       req1_ready;
  logic                       upd_valid;
  logic [PAY_W-1:0]           upd_data;
  logic                       upd_ready;
  logic                       init_we;
  logic [IDX_W-1:0]           init_idx;
  logic [$clog2(DEPTH+1)-1:0] fifo_cnt;
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, upd_ready,
    input  req0_ready, req1_ready, upd_valid, upd_data, init_we, init_idx, fifo_cnt
  );
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, upd_ready,
    output req0_ready, req1_ready, upd_valid, upd_data, init_we, init_idx, fifo_cnt
  );
endinterface

// File: rtl/bpu_update_sched.sv
// bpu_update_sched: sweeps predictor tables clear after reset, then serialises two in-order update slots through a FIFO
module bpu_update_sched #(
  parameter int PAY_W = 64,
  parameter int DEPTH = 4,
  parameter int IDX_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  bpu_update_sched_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] IDX_MAX = '1;
  typedef enum logic [1:0] {RST_HOLD, INIT, RUN} state_t;
  state_t            r_state, w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [PAY_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wp, r_rp, w_wp1;
  logic [CNT_W-1:0]  r_cnt, w_free;
  logic              w_run, w_push0, w_push1, w_pop;
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RST_HOLD;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = r_state == RST_HOLD ? INIT :
             (r_state == INIT && r_idx == IDX_MAX) ? RUN : r_state;
  end
  assign w_run         = r_state == RUN;
  assign w_free        = CNT_W'(DEPTH) - r_cnt;
  // slot 1 needs two credits whenever slot 0 is also presenting, keeping program order
  assign bus.req0_ready = w_run && w_free >= CNT_W'(1);
  assign bus.req1_ready = w_run && (bus.req0_valid ? w_free >= CNT_W'(2) : w_free >= CNT_W'(1));
  assign w_push0       = bus.req0_valid && bus.req0_ready;
  assign w_push1       = bus.req1_valid && bus.req1_ready;
  assign bus.upd_valid = r_cnt != '0;
  assign bus.upd_data  = r_mem[r_rp];
  assign w_pop         = bus.upd_valid && bus.upd_ready;
  assign w_wp1         = r_wp + PTR_W'(1);
  assign bus.init_we   = r_state == INIT;
  assign bus.init_idx  = r_idx;
  assign bus.fifo_cnt  = r_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) r_idx <= '0;
    else r_idx <= (r_state == INIT && r_idx != IDX_MAX) ? r_idx + IDX_W'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + PTR_W'(w_push0) + PTR_W'(w_push1);
      r_rp  <= r_rp + PTR_W'(w_pop);
      r_cnt <= r_cnt + CNT_W'(w_push0) + CNT_W'(w_push1) - CNT_W'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push0) r_mem[r_wp] <= bus.req0_data;
    if (w_push1) r_mem[w_push0 ? w_wp1 : r_wp] <= bus.req1_data;
  end
endmodule

// File: tb/tb_bpu_update_sched.sv
// tb_bpu_update_sched: scoreboard bench for init sweep, dual-slot acceptance, ordering and reset flush
module tb_bpu_update_sched;
  localparam int PAY_W = 64;
  localparam int DEPTH = 4;
  localparam int IDX_W = 4;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  int m_cnt = 0;
  bit m_run = 0;
  logic [PAY_W-1:0] exp_q[$];
  bpu_update_sched_if #(.PAY_W(PAY_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();
  bpu_update_sched #(.PAY_W(PAY_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    bus.req0_data  = '0;
    bus.req1_data  = '0;
    bus.upd_ready  = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle();
    @(negedge clk);
    rst_n = 1;
    m_run = 0;
    m_cnt = 0;
    exp_q.delete();
    #1;
    chk("hold_init_we", 64'(bus.init_we), 0);
    chk("hold_r0", 64'(bus.req0_ready), 0);
    chk("hold_uv", 64'(bus.upd_valid), 0);
    chk("hold_cnt", 64'(bus.fifo_cnt), 0);
    for (int i = 0; i < 2**IDX_W; i++) begin
      @(negedge clk);
      #1;
      chk("sweep_we", 64'(bus.init_we), 1);
      chk("sweep_idx", 64'(bus.init_idx), 64'(i));
      chk("sweep_r0", 64'(bus.req0_ready), 0);
      chk("sweep_r1", 64'(bus.req1_ready), 0);
      chk("sweep_uv", 64'(bus.upd_valid), 0);
    end
    m_run = 1;
  endtask
  task automatic cyc(input bit v0, input logic [63:0] d0, input bit v1, input logic [63:0] d1, input bit ur);
    bit e_r0, e_r1, pop, p0, p1;
    @(negedge clk);
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
    bus.upd_ready  = ur;
    #1;
    e_r0 = m_run && m_cnt < DEPTH;
    e_r1 = m_run && (v0 ? m_cnt <= DEPTH - 2 : m_cnt < DEPTH);
    chk("cnt", 64'(bus.fifo_cnt), 64'(m_cnt));
    chk("uv", 64'(bus.upd_valid), 64'(m_cnt != 0));
    chk("r0", 64'(bus.req0_ready), 64'(e_r0));
    chk("r1", 64'(bus.req1_ready), 64'(e_r1));
    chk("run_we", 64'(bus.init_we), 0);
    chk("run_idx", 64'(bus.init_idx), 0);
    if (exp_q.size() != 0) chk("head", bus.upd_data, exp_q[0]);
    pop = m_cnt != 0 && ur;
    p0 = v0 && e_r0;
    p1 = v1 && e_r1;
    if (pop) void'(exp_q.pop_front());
    if (p0) exp_q.push_back(d0);
    if (p1) exp_q.push_back(d1);
    m_cnt = m_cnt + int'(p0) + int'(p1) - int'(pop);
  endtask
  initial begin
    idle();
    repeat (3) @(negedge clk);
    do_reset();
    cyc(0, 0, 0, 0, 1);
    cyc(1, 64'hA, 1, 64'hB, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 64'h100 + 64'(i), 0, 0, 0);
    cyc(1, 64'h200, 1, 64'h201, 0);
    cyc(1, 64'h300, 1, 64'h301, 0);
    cyc(1, 64'h400, 1, 64'h401, 1);
    cyc(1, 64'h500, 1, 64'h501, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 1000; i++)
      cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom},
          (i % 2 == 0) ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 3) == 0));
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 64'hDEAD0 + 64'(i), 0, 0, 0);
    chk("pre_rst_cnt", 64'(m_cnt), 3);
    do_reset();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 64'hC0DE, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
